// File: rtl/data_memory_multicycle.sv
// Word-addressed data memory with a fixed number of wait states per access.
// A request is latched in IDLE, stalls the pipeline through BUSY, and completes in a one-cycle DONE.
module data_memory_multicycle #(
    parameter int DEPTH   = 256,
    parameter int LATENCY = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic [31:0] Address,
    input  logic [31:0] WriteData,
    output logic [31:0] ReadData,
    output logic        MemReady
);

    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t         r_state;
    state_t         w_next;
    logic [3:0]     r_cnt;
    logic [AW-1:0]  r_idx;
    logic [31:0]    r_wdata;
    logic           r_rd;
    logic           r_wr;
    logic [31:0]    r_rdata;
    logic [31:0]    r_mem [DEPTH];

    logic           w_req;
    logic           w_unused_addr;

    assign w_req         = MemRead | MemWrite;
    // Byte offset and bits above the array size are ignored, so addresses alias modulo DEPTH.
    assign w_unused_addr = ^{Address[31:AW+2], Address[1:0]};
    assign ReadData      = r_rdata;

    always_comb begin
        w_next   = r_state;
        MemReady = 1'b1;
        case (r_state)
            IDLE: begin
                MemReady = ~w_req;
                if (w_req) w_next = BUSY;
            end
            BUSY: begin
                MemReady = 1'b0;
                if (r_cnt == 4'd0) w_next = DONE;
            end
            DONE: begin
                MemReady = 1'b1;
                w_next   = IDLE;
            end
            default: begin
                MemReady = 1'b1;
                w_next   = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
            r_cnt   <= 4'd0;
            r_idx   <= '0;
            r_wdata <= 32'h0;
            r_rd    <= 1'b0;
            r_wr    <= 1'b0;
            r_rdata <= 32'h0;
        end else begin
            r_state <= w_next;
            case (r_state)
                IDLE: begin
                    if (w_req) begin
                        r_cnt   <= 4'(LATENCY - 1);
                        r_idx   <= Address[AW+1:2];
                        r_wdata <= WriteData;
                        r_rd    <= MemRead;
                        r_wr    <= MemWrite;
                    end
                end
                BUSY: begin
                    // A combined read/write samples here, before the write commits on DONE exit.
                    if (r_cnt == 4'd0) begin
                        if (r_rd) r_rdata <= r_mem[r_idx];
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                DONE: begin
                    r_rd <= 1'b0;
                    r_wr <= 1'b0;
                end
                default: begin
                    r_rd <= 1'b0;
                    r_wr <= 1'b0;
                end
            endcase
        end
    end

    // Array has no reset; a reset before the DONE edge drops r_state so the write never lands.
    always_ff @(posedge clk) begin
        if (r_state == DONE && r_wr) r_mem[r_idx] <= r_wdata;
    end

endmodule
